// File: rtl/mux_4_1_rr_arbiter.sv
// mux_4_1_rr_arbiter
// Round-robin arbiter sharing one 4:1 data mux among four valid/ready
// requesters, feeding a single registered valid/ready output stage.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   per-requester valid (bit i -> in_data<i>)
//   in_data0-3 requester data words
//   in_ready   one-hot/zero accept strobe back to the granted requester
//   out_valid  output register holds a word
//   out_ready  downstream accepts the held word this cycle
//   out_data   registered selected word
//   out_src    index of the requester that supplied out_data
module mux_4_1_rr_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src
);

    localparam int unsigned NREQ = 4;

    logic [1:0]       ptr;
    logic             load;
    logic             grant_valid;
    logic [1:0]       grant;
    logic [1:0]       idx;
    logic [WIDTH-1:0] mux_data;
    logic             accept;

    // Output register may take a new word when empty or being drained.
    assign load = !out_valid | out_ready;

    // Round-robin search starting at ptr; walking offsets from far to near
    // lets the nearest valid requester overwrite any farther one.
    always_comb begin
        grant_valid = 1'b0;
        grant       = ptr;
        idx         = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (in_valid[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    // Shared datapath mux driven by the grant index.
    always_comb begin
        mux_data = in_data0;
        case (grant)
            2'd0:    mux_data = in_data0;
            2'd1:    mux_data = in_data1;
            2'd2:    mux_data = in_data2;
            default: mux_data = in_data3;
        endcase
    end

    // Accept strobe: only to the granted requester, never during reset.
    always_comb begin
        in_ready = 4'b0000;
        if (load && grant_valid && !rst) begin
            in_ready = 4'b0001 << grant;
        end
    end

    assign accept = |in_ready;

    // Output register and priority pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            ptr       <= 2'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_src   <= grant;
            ptr       <= grant + 2'd1;
        end else if (load && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed testbench for mux_4_1_rr_arbiter.
module tb_mux_4_1_rr_arbiter;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;

    int checks;
    int errors;

    mux_4_1_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data0 (in_data0),
        .in_data1 (in_data1),
        .in_data2 (in_data2),
        .in_data3 (in_data3),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_src  (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean one-cycle reset with all requests idle.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data0  = 4'h1; in_data1 = 4'h2; in_data2 = 4'h3; in_data3 = 4'h4;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_in_ready cyc%0d: got %b expected 0000", c, in_ready);
            end
            tick();
        end
        rst      = 1'b0;
        in_valid = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 4'h0) begin
            errors++;
            $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
        checks++;
        if (out_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_out_src: got %0d expected 0", out_src);
        end
    endtask

    task automatic test_single();
        in_valid  = 4'b0100;
        in_data2  = 4'hA;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_in_ready: got %b expected 0100", in_ready);
        end
        tick();
        in_valid = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_src !== 2'd2) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h s=%0d expected v=1 d=a s=2",
                     out_valid, out_data, out_src);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_rotation();
        logic [1:0]       exp_src;
        logic [3:0]       exp_rdy;
        logic [WIDTH-1:0] exp_data;
        do_reset();
        in_data0  = 4'h1; in_data1 = 4'h2; in_data2 = 4'h3; in_data3 = 4'h4;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_src  = 2'(i % 4);
            exp_rdy  = 4'b0001 << exp_src;
            exp_data = WIDTH'(exp_src) + 4'h1;
            #1;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rot_in_ready[%0d]: got %b expected %b", i, in_ready, exp_rdy);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== exp_data) begin
                errors++;
                $display("FAIL rot_out[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                         i, out_valid, out_src, out_data, exp_src, exp_data);
            end
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid  = 4'b0010;
        in_data1  = 4'h5;
        out_ready = 1'b1;
        tick();
        in_valid  = 4'b1001;
        in_data0  = 4'h7;
        in_data3  = 4'hC;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_in_ready cyc%0d: got %b expected 0000", c, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'h5 || out_src !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: got v=%b d=%h s=%0d expected v=1 d=5 s=1",
                         c, out_valid, out_data, out_src);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 4'hC) begin
            errors++;
            $display("FAIL bp_release_out: got v=%b s=%0d d=%h expected v=1 s=3 d=c",
                     out_valid, out_src, out_data);
        end
        in_valid = 4'b0001;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_next_ready: got %b expected 0001", in_ready);
        end
        tick();
        checks++;
        if (out_src !== 2'd0 || out_data !== 4'h7) begin
            errors++;
            $display("FAIL bp_next_out: got s=%0d d=%h expected s=0 d=7", out_src, out_data);
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_wrap_skip();
        // ptr is 1 on entry; grant requester 3 so ptr wraps to 0.
        in_valid  = 4'b1000;
        in_data3  = 4'h9;
        in_data0  = 4'h6;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_src !== 2'd3 || out_data !== 4'h9) begin
            errors++;
            $display("FAIL wrap_g3: got s=%0d d=%h expected s=3 d=9", out_src, out_data);
        end
        in_valid = 4'b1001;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_ready0: got %b expected 0001", in_ready);
        end
        tick();
        checks++;
        if (out_src !== 2'd0 || out_data !== 4'h6) begin
            errors++;
            $display("FAIL wrap_g0: got s=%0d d=%h expected s=0 d=6", out_src, out_data);
        end
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL skip_ready3: got %b expected 1000", in_ready);
        end
        tick();
        checks++;
        if (out_src !== 2'd3) begin
            errors++;
            $display("FAIL skip_g3: got s=%0d expected 3", out_src);
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        // ptr is 0 on entry; load requester 0 so ptr moves to 1.
        in_valid  = 4'b0001;
        in_data0  = 4'hE;
        out_ready = 1'b1;
        tick();
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hE) begin
            errors++;
            $display("FAIL mid_held: got v=%b d=%h expected v=1 d=e", out_valid, out_data);
        end
        rst      = 1'b1;
        in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst_ready: got %b expected 0000", in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_out_valid: got %b expected 0", out_valid);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_next_ready: got %b expected 0001", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd0) begin
            errors++;
            $display("FAIL mid_next_out: got v=%b s=%0d expected v=1 s=0", out_valid, out_src);
        end
        in_valid = 4'b0000;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data0  = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_wrap_skip();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
